// File: rtl/difftest_step_scheduler.sv
// Shares one difftest step-service channel between NUM_CORES cores with round-robin batch grants.
// Define DIFFTEST_STEP_SCHED_STATS_EN to add the stat_batches / stat_wait_cycles counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | search eligible cores from the RR pointer, latch a batch
// ST_REQ    | svc_req high, waiting for svc_ack or the wait timeout
// ST_RESULT | one-cycle result_valid pulse, status already decoded
// ST_HALT   | fail or timeout seen; no requests, accumulation frozen
module difftest_step_scheduler #(
   parameter int NUM_CORES  = 2,
   parameter int STEP_WIDTH = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int TIMEOUT    = 1024,
   localparam int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
   input  logic [NUM_CORES-1:0]            core_enable,
   output logic                            svc_req,
   output logic [CW-1:0]                   svc_core,
   output logic [STEP_WIDTH-1:0]           svc_nstep,
   input  logic                            svc_ack,
   input  logic [7:0]                      svc_result,
   output logic                            result_valid,
   output logic [7:0]                      result_code,
   output logic [CW-1:0]                   result_core,
   output logic                            warmup_clean,
   output logic [NUM_CORES-1:0]            core_done,
   output logic                            sim_fail,
   output logic                            timeout_err,
   output logic                            all_done
`ifdef DIFFTEST_STEP_SCHED_STATS_EN
   ,
   output logic [31:0]                     stat_batches,
   output logic [31:0]                     stat_wait_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_RESULT = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   localparam logic [ACC_WIDTH:0]   ACC_MAX    = {1'b0, {ACC_WIDTH{1'b1}}};
   localparam logic [ACC_WIDTH-1:0] BATCH_MAX  = ACC_WIDTH'({STEP_WIDTH{1'b1}});
   localparam logic [31:0]          TIMEOUT_M1 = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_t                  state_q, state_d;
   logic [ACC_WIDTH-1:0]    acc_q [NUM_CORES];
   logic [ACC_WIDTH-1:0]    acc_d [NUM_CORES];
   logic [CW-1:0]           rr_q, rr_d;
   logic                    svc_req_q, svc_req_d;
   logic [CW-1:0]           svc_core_q, svc_core_d;
   logic [STEP_WIDTH-1:0]   svc_nstep_q, svc_nstep_d;
   logic [31:0]             wait_q, wait_d;
   logic                    result_valid_q, result_valid_d;
   logic [7:0]              result_code_q, result_code_d;
   logic [CW-1:0]           result_core_q, result_core_d;
   logic                    warmup_clean_q, warmup_clean_d;
   logic [NUM_CORES-1:0]    core_done_q, core_done_d;
   logic                    sim_fail_q, sim_fail_d;
   logic                    timeout_err_q, timeout_err_d;

   logic [NUM_CORES-1:0]    eligible;
   logic                    sel_found;
   logic [CW-1:0]           sel_idx;
   logic [ACC_WIDTH-1:0]    take;
   logic                    take_en;
   logic                    clr_en;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         eligible[i] = core_enable[i] & ~core_done_q[i] & (acc_q[i] != '0);
      end
   end

   // Rotating priority search starting at the RR pointer.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (!sel_found && eligible[idx]) begin
            sel_found = 1'b1;
            sel_idx   = CW'(idx);
         end
      end
      take = (acc_q[sel_idx] > BATCH_MAX) ? BATCH_MAX : acc_q[sel_idx];
   end

   always_comb begin
      state_d        = state_q;
      rr_d           = rr_q;
      svc_req_d      = svc_req_q;
      svc_core_d     = svc_core_q;
      svc_nstep_d    = svc_nstep_q;
      wait_d         = wait_q;
      result_valid_d = 1'b0;
      result_code_d  = result_code_q;
      result_core_d  = result_core_q;
      warmup_clean_d = 1'b0;
      core_done_d    = core_done_q;
      sim_fail_d     = sim_fail_q;
      timeout_err_d  = timeout_err_q;
      take_en        = 1'b0;
      clr_en         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               state_d     = ST_REQ;
               svc_req_d   = 1'b1;
               svc_core_d  = sel_idx;
               svc_nstep_d = take[STEP_WIDTH-1:0];
               wait_d      = '0;
               take_en     = 1'b1;
               rr_d        = (int'(sel_idx) + 1 >= NUM_CORES) ? '0 : CW'(int'(sel_idx) + 1);
            end
         end
         ST_REQ: begin
            // Status is decoded at the ack edge so it is visible alongside the result pulse.
            if (svc_ack) begin
               state_d        = ST_RESULT;
               svc_req_d      = 1'b0;
               result_valid_d = 1'b1;
               result_code_d  = svc_result;
               result_core_d  = svc_core_q;
               warmup_clean_d = (svc_result == 8'd4);
               if (svc_result == 8'd1 || svc_result == 8'd2) begin
                  core_done_d[svc_core_q] = 1'b1;
                  clr_en                  = 1'b1;
               end
               if (svc_result == 8'd3) sim_fail_d = 1'b1;
            end else if (TIMEOUT > 0 && wait_q == TIMEOUT_M1) begin
               state_d       = ST_HALT;
               svc_req_d     = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end
         ST_RESULT: begin
            state_d = (result_code_q == 8'd3) ? ST_HALT : ST_IDLE;
         end
         ST_HALT: begin
            svc_req_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Add and take are combined into one update so a same-cycle step is never lost.
   always_comb begin
      logic [STEP_WIDTH-1:0] step_i;
      logic [ACC_WIDTH-1:0]  taken;
      logic [ACC_WIDTH:0]    sum;
      step_i = '0;
      taken  = '0;
      sum    = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         step_i = (core_enable[i] && !core_done_q[i]) ? core_step[i*STEP_WIDTH +: STEP_WIDTH] : '0;
         taken  = (take_en && sel_idx == CW'(i)) ? take : '0;
         sum    = {1'b0, acc_q[i]} - {1'b0, taken} + (ACC_WIDTH+1)'(step_i);
         if (state_q == ST_HALT) begin
            acc_d[i] = acc_q[i];
         end else if (clr_en && svc_core_q == CW'(i)) begin
            acc_d[i] = '0;
         end else begin
            acc_d[i] = (sum > ACC_MAX) ? ACC_MAX[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         for (int i = 0; i < NUM_CORES; i++) acc_q[i] <= '0;
         rr_q           <= '0;
         svc_req_q      <= 1'b0;
         svc_core_q     <= '0;
         svc_nstep_q    <= '0;
         wait_q         <= '0;
         result_valid_q <= 1'b0;
         result_code_q  <= '0;
         result_core_q  <= '0;
         warmup_clean_q <= 1'b0;
         core_done_q    <= '0;
         sim_fail_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         for (int i = 0; i < NUM_CORES; i++) acc_q[i] <= acc_d[i];
         rr_q           <= rr_d;
         svc_req_q      <= svc_req_d;
         svc_core_q     <= svc_core_d;
         svc_nstep_q    <= svc_nstep_d;
         wait_q         <= wait_d;
         result_valid_q <= result_valid_d;
         result_code_q  <= result_code_d;
         result_core_q  <= result_core_d;
         warmup_clean_q <= warmup_clean_d;
         core_done_q    <= core_done_d;
         sim_fail_q     <= sim_fail_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign svc_req      = svc_req_q;
   assign svc_core     = svc_core_q;
   assign svc_nstep    = svc_nstep_q;
   assign result_valid = result_valid_q;
   assign result_code  = result_code_q;
   assign result_core  = result_core_q;
   assign warmup_clean = warmup_clean_q;
   assign core_done    = core_done_q;
   assign sim_fail     = sim_fail_q;
   assign timeout_err  = timeout_err_q;
   assign all_done     = (|core_enable) && ((core_done_q & core_enable) == core_enable);

`ifdef DIFFTEST_STEP_SCHED_STATS_EN
   logic [31:0] stat_batches_q, stat_batches_d;
   logic [31:0] stat_wait_q, stat_wait_d;

   always_comb begin
      stat_batches_d = stat_batches_q + (take_en ? 32'd1 : 32'd0);
      stat_wait_d    = stat_wait_q + ((state_q == ST_REQ && !svc_ack) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_batches_q <= '0;
         stat_wait_q    <= '0;
      end else begin
         stat_batches_q <= stat_batches_d;
         stat_wait_q    <= stat_wait_d;
      end
   end

   assign stat_batches     = stat_batches_q;
   assign stat_wait_cycles = stat_wait_q;
`endif

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed-vector bench for difftest_step_scheduler (NUM_CORES=2, STEP_WIDTH=8, TIMEOUT=4).
module tb_difftest_step_scheduler;
   localparam int NC = 2;
   localparam int SW = 8;

   logic             clock       = 1'b0;
   logic             reset       = 1'b0;
   logic [NC*SW-1:0] core_step   = '0;
   logic [NC-1:0]    core_enable = 2'b11;
   logic             svc_ack     = 1'b0;
   logic [7:0]       svc_result  = '0;
   logic             svc_req;
   logic [0:0]       svc_core;
   logic [SW-1:0]    svc_nstep;
   logic             result_valid;
   logic [7:0]       result_code;
   logic [0:0]       result_core;
   logic             warmup_clean;
   logic [NC-1:0]    core_done;
   logic             sim_fail;
   logic             timeout_err;
   logic             all_done;
`ifdef DIFFTEST_STEP_SCHED_STATS_EN
   logic [31:0]      stat_batches;
   logic [31:0]      stat_wait_cycles;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int grant_core[$];
   int grant_n[$];

   difftest_step_scheduler #(
      .NUM_CORES (NC),
      .STEP_WIDTH(SW),
      .ACC_WIDTH (16),
      .TIMEOUT   (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .core_step   (core_step),
      .core_enable (core_enable),
      .svc_req     (svc_req),
      .svc_core    (svc_core),
      .svc_nstep   (svc_nstep),
      .svc_ack     (svc_ack),
      .svc_result  (svc_result),
      .result_valid(result_valid),
      .result_code (result_code),
      .result_core (result_core),
      .warmup_clean(warmup_clean),
      .core_done   (core_done),
      .sim_fail    (sim_fail),
      .timeout_err (timeout_err),
      .all_done    (all_done)
`ifdef DIFFTEST_STEP_SCHED_STATS_EN
      ,
      .stat_batches    (stat_batches),
      .stat_wait_cycles(stat_wait_cycles)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {6'd0, svc_req, svc_core, svc_nstep, result_valid, result_code, result_core,
              warmup_clean, core_done, sim_fail, timeout_err, all_done};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_req(input int max_cyc, input string tag);
      int n = 0;
      while (!svc_req && n < max_cyc) begin
         tick();
         n++;
      end
      check(tag, svc_req, 1);
   endtask

   task automatic ack(input logic [7:0] code);
      svc_ack    = 1'b1;
      svc_result = code;
      tick();
      svc_ack    = 1'b0;
      svc_result = '0;
   endtask

   // Acks every request immediately with the given code and logs each grant.
   task automatic run_auto(input int ncyc, input int nstep_cyc, input logic [7:0] s0,
                           input logic [7:0] s1, input logic [7:0] code);
      grant_core.delete();
      grant_n.delete();
      for (int c = 0; c < ncyc; c++) begin
         core_step = (c < nstep_cyc) ? {s1, s0} : '0;
         if (svc_req) begin
            grant_core.push_back(int'(svc_core));
            grant_n.push_back(int'(svc_nstep));
            svc_ack    = 1'b1;
            svc_result = code;
         end else begin
            svc_ack    = 1'b0;
            svc_result = '0;
         end
         tick();
      end
      svc_ack    = 1'b0;
      svc_result = '0;
      core_step  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      check("outs_in_reset", all_outs(), 0);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int sum;
      int alt_bad;
      int reqs;
      int k;

      // Reset state
      do_reset();
      check("outs_after_reset", all_outs(), 0);

      // Single batch: 3 steps on core0, ack two cycles later with ok
      core_step = {8'd0, 8'd3};
      tick();
      core_step = '0;
      check("t1_no_req_at_1", svc_req, 0);
      tick();
      check("t1_req_at_2", svc_req, 1);
      check("t1_core", svc_core, 0);
      check("t1_nstep", svc_nstep, 3);
      tick();
      check("t1_req_held", svc_req, 1);
      check("t1_nstep_held", svc_nstep, 3);
      ack(8'd0);
      check("t1_rv", result_valid, 1);
      check("t1_code", result_code, 0);
      check("t1_rcore", result_core, 0);
      check("t1_req_dropped", svc_req, 0);
      tick();
      check("t1_rv_pulse", result_valid, 0);
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (svc_req) reqs++;
      end
      check("t1_acc_drained", reqs, 0);

      // Ack outside REQ is ignored
      svc_ack    = 1'b1;
      svc_result = 8'd3;
      tick();
      svc_ack    = 1'b0;
      svc_result = '0;
      tick();
      check("stray_ack_rv", result_valid, 0);
      check("stray_ack_fail", sim_fail, 0);

      // Warmup result on core0
      core_step = {8'd0, 8'd2};
      tick();
      core_step = '0;
      wait_req(5, "wu_req");
      check("wu_core", svc_core, 0);
      check("wu_nstep", svc_nstep, 2);
      ack(8'd4);
      check("wu_code", result_code, 4);
      check("wu_clean", warmup_clean, 1);
      tick();
      check("wu_clean_pulse", warmup_clean, 0);

      // Reserved code on core1 has no effect
      core_step = {8'd5, 8'd0};
      tick();
      core_step = '0;
      wait_req(5, "rsv_req");
      check("rsv_core", svc_core, 1);
      check("rsv_nstep", svc_nstep, 5);
      ack(8'd9);
      check("rsv_code", result_code, 9);
      check("rsv_rcore", result_core, 1);
      check("rsv_done", core_done, 0);
      check("rsv_fail", sim_fail, 0);
      check("rsv_clean", warmup_clean, 0);

      // Both cores step 1 for 20 cycles: strict alternation, nothing lost
      run_auto(60, 20, 8'd1, 8'd1, 8'd0);
      sum     = 0;
      alt_bad = 0;
      foreach (grant_n[i]) sum += grant_n[i];
      for (int i = 1; i < grant_core.size(); i++)
         if (grant_core[i] == grant_core[i-1]) alt_bad++;
      check("rr_sum", sum, 40);
      check("rr_count", grant_core.size(), 9);
      check("rr_alternate", alt_bad, 0);
      check("rr_first", (grant_core.size() > 0) ? grant_core[0] : -1, 0);

      // core1 step 255 for 2 cycles: two full-size batches
      run_auto(20, 2, 8'd0, 8'd255, 8'd0);
      check("big_count", grant_core.size(), 2);
      for (int i = 0; i < grant_n.size(); i++) begin
         check("big_nstep", grant_n[i], 255);
         check("big_core", grant_core[i], 1);
      end

      // goodtrap on core0, then exceed on core1
      run_auto(10, 1, 8'd5, 8'd0, 8'd1);
      check("gt_count", grant_core.size(), 1);
      check("gt_done", core_done, 2'b01);
      check("gt_all_done", all_done, 0);
      run_auto(12, 1, 8'd5, 8'd7, 8'd2);
      check("ex_count", grant_core.size(), 1);
      check("ex_core", (grant_core.size() > 0) ? grant_core[0] : -1, 1);
      check("ex_nstep", (grant_n.size() > 0) ? grant_n[0] : -1, 7);
      check("ex_done", core_done, 2'b11);
      check("ex_all_done", all_done, 1);
      core_enable = 2'b01;
      #1;
      check("ad_one_enabled", all_done, 1);
      core_enable = 2'b00;
      #1;
      check("ad_none_enabled", all_done, 0);
      core_enable = 2'b11;

      // Fail result halts the scheduler
      do_reset();
      core_step = {8'd0, 8'd4};
      tick();
      core_step = '0;
      wait_req(5, "fail_req");
      ack(8'd3);
      check("fail_rv", result_valid, 1);
      check("fail_code", result_code, 3);
      check("fail_sticky", sim_fail, 1);
      reqs = 0;
      core_step = {8'd9, 8'd9};
      for (int i = 0; i < 10; i++) begin
         tick();
         if (svc_req) reqs++;
      end
      core_step = '0;
      check("fail_halt_noreq", reqs, 0);
      check("fail_still", sim_fail, 1);
      reset = 1'b0;
      #2;
      check("fail_async_reset", all_outs(), 0);
      tick();
      reset = 1'b1;
      tick();

      // Reset asserted while a request is pending
      core_step = {8'd0, 8'd6};
      tick();
      core_step = '0;
      wait_req(5, "mid_req");
      reset = 1'b0;
      #1;
      check("mid_req_drop", svc_req, 0);
      tick();
      reset = 1'b1;
      reqs = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (svc_req) reqs++;
      end
      check("mid_batch_discarded", reqs, 0);

      // Ack timeout after 4 cycles
      core_step = {8'd0, 8'd2};
      tick();
      core_step = '0;
      wait_req(5, "to_req");
      k = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (timeout_err && k == 0) k = i;
      end
      check("to_cycles", k, 4);
      check("to_err", timeout_err, 1);
      check("to_req_drop", svc_req, 0);
`ifdef DIFFTEST_STEP_SCHED_STATS_EN
      check("stat_batches", stat_batches, 1);
      check("stat_wait", stat_wait_cycles, 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/difftest_step_scheduler.md
Name: difftest_step_scheduler

Overview:
- Shares one difftest step-service channel (the host-side nstep/compare engine) between NUM_CORES cores.
- Each core reports committed steps every cycle. The block accumulates them per core and grants the channel round-robin.
- It issues bounded step batches, waits for the service's result, then decodes that result into per-core done/fail/warmup status.
- It sits between the per-core difftest step outputs and the simulation endpoint's step/result logic.

Parameters:
- NUM_CORES, 2: number of requesting cores (>=1).
- STEP_WIDTH, 8: width of each core's per-cycle step count and of a service batch.
- ACC_WIDTH, 16: width of each per-core pending-step accumulator (>= STEP_WIDTH).
- TIMEOUT, 1024: max cycles a request may wait for svc_ack; 0 disables the check.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- core_step  input  NUM_CORES*STEP_WIDTH  steps committed this cycle; core i uses bits [i*STEP_WIDTH +: STEP_WIDTH].
- core_enable  input  NUM_CORES  core participates; when 0 the core is never granted and is excluded from all_done.
- svc_req  output  1  batch request valid.
- svc_core  output  max(1,$clog2(NUM_CORES))  core id of the batch.
- svc_nstep  output  STEP_WIDTH  step count of the batch.
- svc_ack  input  1  one-cycle pulse: batch processed; svc_result valid.
- svc_result  input  8  0 ok, 1 goodtrap, 2 exceed, 3 fail, 4 warmup, other values reserved.
- result_valid  output  1  one-cycle pulse per decoded result.
- result_code  output  8  copy of svc_result for the pulse.
- result_core  output  as svc_core  core id for the pulse.
- warmup_clean  output  1  one-cycle pulse on result 4 (perf-counter clean).
- core_done  output  NUM_CORES  sticky; set on goodtrap/exceed for that core.
- sim_fail  output  1  sticky; set on result 3.
- timeout_err  output  1  sticky; set on ack timeout.
- all_done  output  1  combinational: every enabled core has core_done set, and at least one core is enabled.

Behaviour:
- Reset (async assert, sync release): all outputs 0, accumulators 0, RR pointer 0, FSM in IDLE.
- Accumulate every cycle: acc[i] <= sat(acc[i] + core_step[i] - issued[i]).
  - Saturates at 2^ACC_WIDTH-1.
  - issued[i] is the batch size taken this cycle.
  - A same-cycle add and take must not lose steps.
  - core_step is ignored for done or disabled cores.
- Eligible core: core_enable=1, core_done=0, acc>0.
- FSM IDLE:
  - Search eligible cores starting at the RR pointer, wrapping around.
  - On a hit, latch svc_core=i and svc_nstep=min(acc[i], 2^STEP_WIDTH-1), subtract that amount from acc[i], go to REQ.
  - Advance the RR pointer to i+1 (mod NUM_CORES).
- FSM REQ:
  - svc_req=1; svc_core and svc_nstep are held stable.
  - On svc_ack: capture svc_result, drop svc_req in the same cycle, go to RESULT.
  - Wait counter counts from 0. If TIMEOUT>0 and the counter reaches TIMEOUT before ack, set timeout_err and go to HALT.
- FSM RESULT (1 cycle):
  - result_valid=1; result_core and result_code are driven.
  - Code 1/2: set core_done[core] and clear its accumulator.
  - Code 3: set sim_fail and go to HALT.
  - Code 4: warmup_clean=1.
  - Codes 0/4/reserved: otherwise no effect.
  - Go to IDLE, except on code 3.
- FSM HALT: svc_req=0; accumulation frozen; exit only via reset.
- Minimum latency: core step to svc_req = 2 cycles (accumulate, then IDLE select). Steady-state: one batch per ack + 2 cycles.
- svc_ack outside REQ is ignored.
- Reset asserted mid-REQ: svc_req drops immediately (async); the pending batch is discarded.
- NUM_CORES=1: the RR pointer is constant 0.

Optional Feature:
- Macro: DIFFTEST_STEP_SCHED_STATS_EN.
- Defined: adds two outputs.
  - stat_batches (32-bit): increments on every entry to REQ.
  - stat_wait_cycles (32-bit): increments on every cycle in REQ without svc_ack.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- NUM_CORES=2; core0 step=3 for 1 cycle, ack after 2 cycles with result 0 -> svc_req at cycle+2 with svc_core=0, svc_nstep=3; one result_valid with code 0; acc0=0.
- Both cores step=1 every cycle, ack every REQ immediately -> svc_core alternates 0,1,0,1; no steps lost (sum of svc_nstep equals sum of core_step after drain).
- core1 step=255 for 2 cycles -> two batches of 255 each, with none exceeding 255.
- Ack with result 1 for core0 -> core_done=01; core0 never granted again. Then result 2 for core1 -> core_done=11, all_done=1.
- Ack result 3 -> sim_fail=1, svc_req stays 0 despite pending steps. Then reset low -> all outputs 0.
- TIMEOUT=4, no ack -> timeout_err=1 exactly 4 cycles after svc_req rises; svc_req drops. With the STATS macro defined: stat_batches=1, stat_wait_cycles=4.
